time_set_ctrl: RTL and testbench



---
 rtl/clock_pkg.sv | 44 ++++
 rtl/btn_repeat.sv | 50 +++++
 rtl/time_set_ctrl.sv | 157 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock front panel: debouncer button codes,
// time-setting FSM state encoding, field limits and wrap-around helpers.
package clock_pkg;

    typedef logic [1:0] btn_code_t;
    typedef logic [1:0] state_t;
    typedef logic [1:0] blink_t;

    // Debouncer output codes
    localparam btn_code_t BTN_IDLE  = 2'b11;
    localparam btn_code_t BTN_SHORT = 2'b10;
    localparam btn_code_t BTN_LONG  = 2'b01;
    localparam btn_code_t BTN_HELD  = 2'b00;

    // Edit FSM states
    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_SET_H = 2'd1;
    localparam state_t ST_SET_M = 2'd2;

    // Field being edited, as shown on the display
    localparam blink_t BLINK_NONE  = 2'b00;
    localparam blink_t BLINK_HOURS = 2'b01;
    localparam blink_t BLINK_MIN   = 2'b10;

    localparam logic [4:0] HOURS_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX   = 6'd59;

    // Hours +/-1 modulo 24
    function automatic logic [4:0] hours_step(input logic [4:0] h, input logic up);
        if (up) begin
            return (h >= HOURS_MAX) ? 5'd0 : h + 5'd1;
        end
        return (h == 5'd0) ? HOURS_MAX : h - 5'd1;
    endfunction

    // Minutes +/-1 modulo 60
    function automatic logic [5:0] minutes_step(input logic [5:0] m, input logic up);
        if (up) begin
            return (m >= MIN_MAX) ? 6'd0 : m + 6'd1;
        end
        return (m == 6'd0) ? MIN_MAX : m - 6'd1;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Turns one debounced button code into increment/decrement pulses.
// Short press increments, long press decrements, and a held button
// increments on its first held cycle and then every REPEAT_DIV cycles.
module btn_repeat
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DIV = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  btn_code_t i_code,
    input  logic      i_clear,
    output logic      o_inc_pulse,
    output logic      o_dec_pulse
);

    // Counter wraps after this value; a divider of 0 or 1 repeats every cycle
    localparam logic [31:0] RPT_LAST = (REPEAT_DIV > 1) ? 32'(REPEAT_DIV - 1) : 32'd0;

    logic [31:0] cnt_q, cnt_d;
    logic        held;

    // Repeat phase counter; restarts whenever the hold is broken or cleared
    always_comb begin
        held = (i_code == BTN_HELD) && !i_clear;
        if (!held) begin
            cnt_d = 32'd0;
        end else if (cnt_q >= RPT_LAST) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Pulses are combinational so steps land in the same edge as other events
    always_comb begin
        o_inc_pulse = !i_clear && ((i_code == BTN_SHORT) || (held && (cnt_q == 32'd0)));
        o_dec_pulse = !i_clear && (i_code == BTN_LONG);
    end

    // Counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: MODE enters/steps/commits an hours-then-minutes
// edit, ADJ adjusts the selected field with wrap-around and auto-repeat,
// and an idle timeout abandons the edit without loading.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DIV_CONST  = 50_000_000,
    parameter int unsigned REPEAT_DIV = DIV_CONST / 4,
    parameter int unsigned TIMEOUT_S  = 30
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_mode_state,
    input  logic [1:0] i_adj_state,
    input  logic [4:0] i_hours,
    input  logic [5:0] i_minutes,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic       o_load,
    output logic       o_editing,
    output logic [1:0] o_blink_sel
);

    localparam logic [31:0] TO_RELOAD = 32'(TIMEOUT_S * DIV_CONST);

    state_t      state_q, state_d;
    logic [4:0]  hours_q, hours_d;
    logic [5:0]  minutes_q, minutes_d;
    logic        load_q, load_d;
    logic        editing_q, editing_d;
    blink_t      blink_q, blink_d;
    logic [31:0] to_q, to_d;

    logic        in_edit;
    logic        mode_evt;
    logic        any_evt;
    logic        rpt_clear;
    logic        adj_inc;
    logic        adj_dec;

    // Classify this cycle's inputs; a MODE event suppresses ADJ entirely
    always_comb begin
        in_edit   = (state_q != ST_RUN);
        mode_evt  = in_edit ? ((i_mode_state == BTN_SHORT) || (i_mode_state == BTN_LONG))
                            : (i_mode_state == BTN_LONG);
        any_evt   = (i_mode_state != BTN_IDLE) || (i_adj_state != BTN_IDLE);
        rpt_clear = !in_edit || mode_evt;
    end

    btn_repeat #(
        .REPEAT_DIV (REPEAT_DIV)
    ) u_adj_repeat (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_code      (i_adj_state),
        .i_clear     (rpt_clear),
        .o_inc_pulse (adj_inc),
        .o_dec_pulse (adj_dec)
    );

    // Next-state: timeout bookkeeping first, then button-driven transitions
    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        load_d    = 1'b0;
        to_d      = to_q;

        // Any button activity keeps the edit alive; silence counts down
        if (any_evt) begin
            to_d = TO_RELOAD;
        end else if (in_edit) begin
            if (to_q <= 32'd1) begin
                to_d    = 32'd0;
                state_d = ST_RUN;
            end else begin
                to_d = to_q - 32'd1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (i_mode_state == BTN_LONG) begin
                    state_d   = ST_SET_H;
                    to_d      = TO_RELOAD;
                    hours_d   = (i_hours > HOURS_MAX) ? 5'd0 : i_hours;
                    minutes_d = (i_minutes > MIN_MAX) ? 6'd0 : i_minutes;
                end
            end
            ST_SET_H: begin
                if (i_mode_state == BTN_SHORT) begin
                    state_d = ST_SET_M;
                end else if (i_mode_state == BTN_LONG) begin
                    load_d  = 1'b1;
                    state_d = ST_RUN;
                end else if (adj_inc) begin
                    hours_d = hours_step(hours_q, 1'b1);
                end else if (adj_dec) begin
                    hours_d = hours_step(hours_q, 1'b0);
                end
            end
            ST_SET_M: begin
                if (i_mode_state == BTN_SHORT) begin
                    state_d = ST_SET_H;
                end else if (i_mode_state == BTN_LONG) begin
                    load_d  = 1'b1;
                    state_d = ST_RUN;
                end else if (adj_inc) begin
                    minutes_d = minutes_step(minutes_q, 1'b1);
                end else if (adj_dec) begin
                    minutes_d = minutes_step(minutes_q, 1'b0);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Status outputs follow the next state so they line up with the edit registers
    always_comb begin
        editing_d = (state_d != ST_RUN);
        case (state_d)
            ST_SET_H: blink_d = BLINK_HOURS;
            ST_SET_M: blink_d = BLINK_MIN;
            default:  blink_d = BLINK_NONE;
        endcase
    end

    // State, edit registers, timeout counter and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_RUN;
            hours_q   <= 5'd0;
            minutes_q <= 6'd0;
            load_q    <= 1'b0;
            editing_q <= 1'b0;
            blink_q   <= BLINK_NONE;
            to_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            load_q    <= load_d;
            editing_q <= editing_d;
            blink_q   <= blink_d;
            to_q      <= to_d;
        end
    end

    assign o_hours     = hours_q;
    assign o_minutes   = minutes_q;
    assign o_load      = load_q;
    assign o_editing   = editing_q;
    assign o_blink_sel = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a small clock divider so the
// auto-repeat and timeout paths are reachable in a few dozen cycles.
module tb_time_set_ctrl;

    localparam logic [1:0] IDLE  = 2'b11;
    localparam logic [1:0] SHORT = 2'b10;
    localparam logic [1:0] LONG  = 2'b01;
    localparam logic [1:0] HELD  = 2'b00;

    // Divider 8, repeat every 4 cycles, 2 s timeout -> 16 idle cycles
    localparam int unsigned DIV = 8;
    localparam int unsigned RPT = 4;
    localparam int unsigned TOS = 2;
    localparam int          TO_CYC = 16;

    logic       i_clk;
    logic       i_rst_n;
    logic [1:0] i_mode_state;
    logic [1:0] i_adj_state;
    logic [4:0] i_hours;
    logic [5:0] i_minutes;
    logic [4:0] o_hours;
    logic [5:0] o_minutes;
    logic       o_load;
    logic       o_editing;
    logic [1:0] o_blink_sel;

    int total = 0;
    int bad   = 0;

    time_set_ctrl #(
        .DIV_CONST  (DIV),
        .REPEAT_DIV (RPT),
        .TIMEOUT_S  (TOS)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_mode_state (i_mode_state),
        .i_adj_state  (i_adj_state),
        .i_hours      (i_hours),
        .i_minutes    (i_minutes),
        .o_hours      (o_hours),
        .o_minutes    (o_minutes),
        .o_load       (o_load),
        .o_editing    (o_editing),
        .o_blink_sel  (o_blink_sel)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One-cycle debouncer pulse on MODE/ADJ, then sample 1 time unit after the edge
    task automatic pulse(input logic [1:0] m, input logic [1:0] a);
        i_mode_state = m;
        i_adj_state  = a;
        @(posedge i_clk);
        #1;
        i_mode_state = IDLE;
        i_adj_state  = IDLE;
    endtask

    task automatic idle_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic load_seen;
        i_rst_n      = 1'b0;
        i_mode_state = IDLE;
        i_adj_state  = IDLE;
        i_hours      = 5'd0;
        i_minutes    = 6'd0;
        #2;
        check("rst_hours",   32'(o_hours),     32'd0);
        check("rst_minutes", 32'(o_minutes),   32'd0);
        check("rst_load",    32'(o_load),      32'd0);
        check("rst_editing", 32'(o_editing),   32'd0);
        check("rst_blink",   32'(o_blink_sel), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Enter edit with a capture of the running time
        i_hours   = 5'd12;
        i_minutes = 6'd34;
        pulse(LONG, IDLE);
        check("cap_editing", 32'(o_editing),   32'd1);
        check("cap_blink",   32'(o_blink_sel), 32'd1);
        check("cap_hours",   32'(o_hours),     32'd12);
        check("cap_minutes", 32'(o_minutes),   32'd34);
        check("cap_load",    32'(o_load),      32'd0);

        pulse(IDLE, SHORT);
        check("h_inc", 32'(o_hours), 32'd13);
        pulse(IDLE, LONG);
        pulse(IDLE, LONG);
        check("h_dec2", 32'(o_hours), 32'd11);

        // Commit from SET_H
        pulse(LONG, IDLE);
        check("commit1_load",    32'(o_load),      32'd1);
        check("commit1_hours",   32'(o_hours),     32'd11);
        check("commit1_minutes", 32'(o_minutes),   32'd34);
        check("commit1_editing", 32'(o_editing),   32'd0);
        check("commit1_blink",   32'(o_blink_sel), 32'd0);
        idle_cycle();
        check("commit1_load_off", 32'(o_load), 32'd0);

        // Hours wrap both ways
        i_hours   = 5'd23;
        i_minutes = 6'd59;
        pulse(LONG, IDLE);
        check("cap2_hours", 32'(o_hours), 32'd23);
        pulse(IDLE, SHORT);
        check("h_wrap_up", 32'(o_hours), 32'd0);
        pulse(IDLE, LONG);
        check("h_wrap_dn", 32'(o_hours), 32'd23);

        // Minutes field, wrap both ways
        pulse(SHORT, IDLE);
        check("setm_blink",   32'(o_blink_sel), 32'd2);
        check("setm_editing", 32'(o_editing),   32'd1);
        pulse(IDLE, SHORT);
        check("m_wrap_up", 32'(o_minutes), 32'd0);
        pulse(IDLE, LONG);
        check("m_wrap_dn", 32'(o_minutes), 32'd59);
        pulse(IDLE, LONG);
        check("m_dec", 32'(o_minutes), 32'd58);

        // Held ADJ for 3*RPT+1 cycles: steps on cycles 1, 5, 9, 13 -> 59, 0, 1, 2
        i_adj_state = HELD;
        for (int i = 1; i <= 3 * RPT + 1; i++) begin
            @(posedge i_clk);
            #1;
            check($sformatf("rpt_%0d", i), 32'(o_minutes), 32'((58 + (i - 1) / 4 + 1) % 60));
        end
        i_adj_state = IDLE;
        repeat (6) idle_cycle();
        check("rpt_release_min", 32'(o_minutes), 32'd2);
        check("rpt_hours_kept",  32'(o_hours),   32'd23);

        // MODE beats ADJ in the same cycle
        pulse(SHORT, IDLE);
        check("back_seth_blink", 32'(o_blink_sel), 32'd1);
        pulse(SHORT, SHORT);
        check("prio_blink",   32'(o_blink_sel), 32'd2);
        check("prio_hours",   32'(o_hours),     32'd23);
        check("prio_minutes", 32'(o_minutes),   32'd2);
        pulse(LONG, IDLE);
        check("commit2_load",    32'(o_load),    32'd1);
        check("commit2_hours",   32'(o_hours),   32'd23);
        check("commit2_minutes", 32'(o_minutes), 32'd2);
        check("commit2_editing", 32'(o_editing), 32'd0);
        idle_cycle();
        check("commit2_load_off", 32'(o_load),      32'd0);
        check("commit2_blink",    32'(o_blink_sel), 32'd0);

        // Out-of-range capture clamps to zero
        i_hours   = 5'd30;
        i_minutes = 6'd61;
        pulse(LONG, IDLE);
        check("clamp_hours",   32'(o_hours),   32'd0);
        check("clamp_minutes", 32'(o_minutes), 32'd0);

        // Timeout: last event reloads, then TO_CYC silent cycles leave the edit
        pulse(IDLE, SHORT);
        pulse(IDLE, SHORT);
        check("to_hours_pre", 32'(o_hours), 32'd2);
        load_seen = 1'b0;
        for (int i = 1; i < TO_CYC; i++) begin
            idle_cycle();
            if (o_load) load_seen = 1'b1;
        end
        check("to_still_editing", 32'(o_editing), 32'd1);
        idle_cycle();
        if (o_load) load_seen = 1'b1;
        check("to_exit_editing", 32'(o_editing),   32'd0);
        check("to_exit_blink",   32'(o_blink_sel), 32'd0);
        check("to_hours_kept",   32'(o_hours),     32'd2);
        repeat (3) begin
            idle_cycle();
            if (o_load) load_seen = 1'b1;
        end
        check("to_no_load", 32'(load_seen), 32'd0);

        // Asynchronous reset mid-edit
        i_hours   = 5'd7;
        i_minutes = 6'd8;
        pulse(LONG, IDLE);
        pulse(IDLE, SHORT);
        check("arst_pre_hours",   32'(o_hours),   32'd8);
        check("arst_pre_editing", 32'(o_editing), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_hours",   32'(o_hours),     32'd0);
        check("arst_minutes", 32'(o_minutes),   32'd0);
        check("arst_load",    32'(o_load),      32'd0);
        check("arst_editing", 32'(o_editing),   32'd0);
        check("arst_blink",   32'(o_blink_sel), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        idle_cycle();
        check("arst_after_editing", 32'(o_editing), 32'd0);
        check("arst_after_load",    32'(o_load),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
